// File: rtl/bram_port_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | bram_port_arbiter_if : requester, response and RAM-pin bundle for the arbiter |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface bram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 8
);
  logic                  req0_valid;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_ready;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;

  logic                  req1_valid;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_ready;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

`default_nettype wire

// File: rtl/bram_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | bram_port_arbiter : round-robin, burst-bounded sharing of one single-port RAM |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  wire logic           clk,
  input  wire logic           reset,
  bram_port_arbiter_if.slave  bus
);

  localparam int              CNT_W   = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             rd_pend0_q, rd_pend1_q;
  logic             gnt0, gnt1;
  logic             at_limit;

  assign at_limit = (burst_cnt_q == CNT_MAX);

  // Owner yields only when the other side is waiting and the burst budget is spent.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state_q)
        OWN0: begin
          if (bus.req0_valid && !(bus.req1_valid && at_limit)) gnt0 = 1'b1;
          else if (bus.req1_valid)                              gnt1 = 1'b1;
        end
        OWN1: begin
          if (bus.req1_valid && !(bus.req0_valid && at_limit)) gnt1 = 1'b1;
          else if (bus.req0_valid)                              gnt0 = 1'b1;
        end
        default: begin
          if (bus.req0_valid)      gnt0 = 1'b1;
          else if (bus.req1_valid) gnt1 = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_d     = IDLE;
    burst_cnt_d = '0;
    if (gnt0) begin
      state_d     = OWN0;
      burst_cnt_d = (state_q != OWN0) ? CNT_W'(1) :
                    (at_limit ? CNT_MAX : burst_cnt_q + 1'b1);
    end else if (gnt1) begin
      state_d     = OWN1;
      burst_cnt_d = (state_q != OWN1) ? CNT_W'(1) :
                    (at_limit ? CNT_MAX : burst_cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      rd_pend0_q  <= 1'b0;
      rd_pend1_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend0_q  <= gnt0 & ~bus.req0_we;
      rd_pend1_q  <= gnt1 & ~bus.req1_we;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  assign bus.ram_addr  = gnt0 ? bus.req0_addr  : (gnt1 ? bus.req1_addr  : {ADDR_WIDTH{1'b0}});
  assign bus.ram_wdata = gnt0 ? bus.req0_wdata : (gnt1 ? bus.req1_wdata : {DATA_WIDTH{1'b0}});
  assign bus.ram_we    = (gnt0 & bus.req0_we) | (gnt1 & bus.req1_we);

  // Gating with reset drops a response that was in flight when reset rose.
  assign bus.rsp0_valid = rd_pend0_q & ~reset;
  assign bus.rsp1_valid = rd_pend1_q & ~reset;
  assign bus.rsp0_rdata = bus.rsp0_valid ? bus.ram_rdata : {DATA_WIDTH{1'b0}};
  assign bus.rsp1_rdata = bus.rsp1_valid ? bus.ram_rdata : {DATA_WIDTH{1'b0}};

endmodule

`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_bram_port_arbiter : directed self-checking bench with a registered RAM model |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bram_port_arbiter;
  localparam int ADDR_WIDTH = 18;
  localparam int DATA_WIDTH = 8;
  localparam int BURST_MAX  = 4;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  bram_port_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  bram_port_arbiter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model with registered read data.
  logic [DATA_WIDTH-1:0] mem [0:1023];
  logic [DATA_WIDTH-1:0] r_ram_rdata;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr[9:0]] <= bus.ram_wdata;
    r_ram_rdata <= mem[bus.ram_addr[9:0]];
  end
  assign bus.ram_rdata = r_ram_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp0;
    logic prev0;
    tests_run    = 0;
    tests_failed = 0;
    prev0        = 1'b0;
    reset        = 1'b1;
    clear_reqs();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[5] = 8'hA5;
    mem[6] = 8'h5A;

    // Reset: requests are ignored and RAM pins stay quiet
    step();
    bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 18'h00005; bus.req0_wdata = 8'h77;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    check("rst_rdy0",   32'(bus.req0_ready), 32'd0);
    check("rst_rdy1",   32'(bus.req1_ready), 32'd0);
    check("rst_we",     32'(bus.ram_we),     32'd0);
    check("rst_addr",   32'(bus.ram_addr),   32'd0);
    check("rst_wdata",  32'(bus.ram_wdata),  32'd0);
    check("rst_rsp0v",  32'(bus.rsp0_valid), 32'd0);
    check("rst_rsp0d",  32'(bus.rsp0_rdata), 32'd0);
    step();
    reset = 1'b0;
    clear_reqs();

    // Single read by req0
    step();
    bus.req0_valid = 1'b1; bus.req0_addr = 18'h00005;
    @(negedge clk);
    check("t1_rdy0",  32'(bus.req0_ready), 32'd1);
    check("t1_addr",  32'(bus.ram_addr),   32'h5);
    check("t1_we",    32'(bus.ram_we),     32'd0);
    check("t1_rsp0a", 32'(bus.rsp0_valid), 32'd0);
    step();
    clear_reqs();
    @(negedge clk);
    check("t1_rsp0v", 32'(bus.rsp0_valid), 32'd1);
    check("t1_rdata", 32'(bus.rsp0_rdata), 32'hA5);
    check("t1_rsp1v", 32'(bus.rsp1_valid), 32'd0);
    step();
    @(negedge clk);
    check("t1_rsp0_off", 32'(bus.rsp0_valid), 32'd0);
    check("t1_rdata_off", 32'(bus.rsp0_rdata), 32'd0);

    // Contention: bursts of four alternate 0000 1111 0000
    step();
    bus.req0_valid = 1'b1; bus.req0_addr = 18'h00005;
    bus.req1_valid = 1'b1; bus.req1_addr = 18'h00006;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp0 = (((i / 4) % 2) == 0);
      check($sformatf("t2_rdy0_%0d", i), 32'(bus.req0_ready), 32'(exp0));
      check($sformatf("t2_rdy1_%0d", i), 32'(bus.req1_ready), 32'(!exp0));
      if (i > 0) begin
        check($sformatf("t2_rsp0v_%0d", i), 32'(bus.rsp0_valid), 32'(prev0));
        check($sformatf("t2_rsp1v_%0d", i), 32'(bus.rsp1_valid), 32'(!prev0));
        if (prev0) check($sformatf("t2_d0_%0d", i), 32'(bus.rsp0_rdata), 32'hA5);
        else       check($sformatf("t2_d1_%0d", i), 32'(bus.rsp1_rdata), 32'h5A);
      end
      prev0 = exp0;
      step();
    end
    clear_reqs();
    @(negedge clk);
    check("t2_last_rsp0v", 32'(bus.rsp0_valid), 32'd1);
    check("t2_last_rdy0",  32'(bus.req0_ready), 32'd0);

    // Write by req0 then read-after-write by req1
    step();
    bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 18'h00010; bus.req0_wdata = 8'h3C;
    bus.req1_valid = 1'b1; bus.req1_addr = 18'h00010;
    @(negedge clk);
    check("t3_rdy0",  32'(bus.req0_ready), 32'd1);
    check("t3_rdy1",  32'(bus.req1_ready), 32'd0);
    check("t3_we",    32'(bus.ram_we),     32'd1);
    check("t3_wdata", 32'(bus.ram_wdata),  32'h3C);
    check("t3_waddr", 32'(bus.ram_addr),   32'h10);
    step();
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0;
    @(negedge clk);
    check("t3_rdy1_n1", 32'(bus.req1_ready), 32'd1);
    check("t3_we_n1",   32'(bus.ram_we),     32'd0);
    check("t3_rsp0v_a", 32'(bus.rsp0_valid), 32'd0);
    step();
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("t3_rsp1v",   32'(bus.rsp1_valid), 32'd1);
    check("t3_rdata",   32'(bus.rsp1_rdata), 32'h3C);
    check("t3_rsp0v_b", 32'(bus.rsp0_valid), 32'd0);

    // Tie from IDLE, single op each, then back to IDLE
    step();
    bus.req0_valid = 1'b1; bus.req0_addr = 18'h00005;
    bus.req1_valid = 1'b1; bus.req1_addr = 18'h00006;
    @(negedge clk);
    check("t4_rdy0", 32'(bus.req0_ready), 32'd1);
    check("t4_rdy1", 32'(bus.req1_ready), 32'd0);
    step();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("t4_rdy1_n1", 32'(bus.req1_ready), 32'd1);
    step();
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("t4_rsp1v", 32'(bus.rsp1_valid), 32'd1);
    check("t4_rsp1d", 32'(bus.rsp1_rdata), 32'h5A);
    step();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    check("t4_idle_rdy0", 32'(bus.req0_ready), 32'd1);
    check("t4_idle_rdy1", 32'(bus.req1_ready), 32'd0);
    step();
    clear_reqs();

    // Reset while a req1 read response is pending
    step();
    bus.req1_valid = 1'b1; bus.req1_addr = 18'h00006;
    @(negedge clk);
    check("t5_rdy1", 32'(bus.req1_ready), 32'd1);
    step();
    reset = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_addr = 18'h00005;
    @(negedge clk);
    check("t5_rsp1v", 32'(bus.rsp1_valid), 32'd0);
    check("t5_rsp1d", 32'(bus.rsp1_rdata), 32'd0);
    check("t5_rdy0",  32'(bus.req0_ready), 32'd0);
    check("t5_rdy1r", 32'(bus.req1_ready), 32'd0);
    step();
    @(negedge clk);
    check("t5_state", 32'(dut.state_q),     32'd0);
    check("t5_cnt",   32'(dut.burst_cnt_q), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t5_post_rsp1v", 32'(bus.rsp1_valid), 32'd0);
    check("t5_post_rdy0",  32'(bus.req0_ready), 32'd1);
    check("t5_post_rdy1",  32'(bus.req1_ready), 32'd0);
    step();
    clear_reqs();

    // Uncontended streaming by req1; counter saturates then yields at once
    step();
    bus.req1_valid = 1'b1; bus.req1_addr = 18'h00006;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("t6_rdy1_%0d", i), 32'(bus.req1_ready), 32'd1);
      step();
    end
    bus.req0_valid = 1'b1; bus.req0_addr = 18'h00005;
    @(negedge clk);
    check("t6_cnt_sat", 32'(dut.burst_cnt_q), 32'd4);
    check("t6_yield0",  32'(bus.req0_ready),  32'd1);
    check("t6_yield1",  32'(bus.req1_ready),  32'd0);
    check("t6_rsp1v",   32'(bus.rsp1_valid),  32'd1);
    step();
    clear_reqs();
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

`default_nettype wire
